// File: rtl/magma_pkg.sv
// Shared definitions for the Magma (GOST R 34.12-2015, 64-bit block) core.
// Holds the S-box set (id-tc26-gost-28147-param-Z), round/block counts,
// the FSM state encoding and the per-round key index selection.
package magma_pkg;

    localparam int ROUNDS = 32;
    localparam int BLOCKS = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SBOX[n][x]: substitution for nibble n (nibble 0 is the LSB) of input x.
    localparam logic [3:0] SBOX [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    // Zero-based round-key index (0 = K1 ... 7 = K8) for round rnd.
    // Encrypt: K1..K8 three times, then K8..K1.
    // Decrypt: K1..K8 once, then K8..K1 three times.
    function automatic logic [2:0] key_index(input logic [4:0] rnd, input logic decrypt);
        logic ascending;
        ascending = decrypt ? (rnd < 5'd8) : (rnd < 5'd24);
        return ascending ? rnd[2:0] : (3'd7 - rnd[2:0]);
    endfunction

endpackage

// File: rtl/magma_round.sv
// One combinational Magma round.
//   a1, a0     : upper / lower halves of the current block
//   k          : 32-bit round key
//   last       : final round (no half swap)
//   next_block : block after this round
// g(k,a) = rotl11(S(a + k mod 2^32)); normal rounds produce (a0, g^a1),
// the last round produces (g^a1, a0).
module magma_round
    import magma_pkg::*;
(
    input  logic [31:0] a1,
    input  logic [31:0] a0,
    input  logic [31:0] k,
    input  logic        last,
    output logic [63:0] next_block
);

    logic [31:0] sum;
    logic [31:0] subst;
    logic [31:0] g_out;
    logic [31:0] mixed;

    always_comb begin
        sum   = a0 + k;
        subst = '0;
        for (int n = 0; n < 8; n++) begin
            subst[4*n +: 4] = SBOX[n][sum[4*n +: 4]];
        end
        g_out      = {subst[20:0], subst[31:21]};
        mixed      = g_out ^ a1;
        next_block = last ? {mixed, a0} : {a0, mixed};
    end

endmodule

// File: rtl/magma_core.sv
// Two-block Magma ECB engine, one round per clock.
//   clk      : system clock
//   reset    : synchronous, active-low
//   start    : request strobe, only honoured in IDLE
//   decrypt  : 0 = encrypt, 1 = decrypt (sampled with start)
//   key      : K1 = key[255:224] ... K8 = key[31:0]
//   data_in  : B0 = [63:0], B1 = [127:64]
//   data_out : R0 = [63:0], R1 = [127:64], held until the next completion
//   busy     : operation in progress
//   done     : one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start; all operand registers hold
// RUN   | one round per edge, B0 then B1 (64 edges in total)
module magma_core
    import magma_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         decrypt,
    input  logic [255:0] key,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    state_t         state_q;
    state_t         state_d;
    logic [4:0]     rnd_q;
    logic           blk_q;
    logic [63:0]    block_q;
    logic [63:0]    b1_q;
    logic [255:0]   key_q;
    logic           decrypt_q;
    logic [63:0]    r0_q;
    logic [127:0]   data_out_q;
    logic           done_q;

    logic           last;
    logic           final_block;
    logic [2:0]     word_sel;
    logic [31:0]    round_key;
    logic [63:0]    round_out;

    assign last        = (rnd_q == 5'(ROUNDS - 1));
    assign final_block = (blk_q == 1'(BLOCKS - 1));

    // K1 sits in the top word, so key index i maps to word (7 - i) from the LSB.
    assign word_sel  = 3'd7 - key_index(rnd_q, decrypt_q);
    assign round_key = key_q[{word_sel, 5'b0} +: 32];

    magma_round u_round (
        .a1         (block_q[63:32]),
        .a0         (block_q[31:0]),
        .k          (round_key),
        .last       (last),
        .next_block (round_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last && final_block) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rnd_q      <= '0;
            blk_q      <= 1'b0;
            block_q    <= '0;
            b1_q       <= '0;
            key_q      <= '0;
            decrypt_q  <= 1'b0;
            r0_q       <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        key_q     <= key;
                        decrypt_q <= decrypt;
                        block_q   <= data_in[63:0];
                        b1_q      <= data_in[127:64];
                        rnd_q     <= '0;
                        blk_q     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // 5-bit counter wraps from 31 to 0 between blocks.
                    rnd_q <= rnd_q + 5'd1;
                    if (!last) begin
                        block_q <= round_out;
                    end else if (!final_block) begin
                        r0_q    <= round_out;
                        block_q <= b1_q;
                        blk_q   <= 1'b1;
                    end else begin
                        data_out_q <= {round_out, r0_q};
                        done_q     <= 1'b1;
                        blk_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_magma_core.sv
// Directed and randomized checks of magma_core against a plain behavioural
// Magma model (key schedule as an explicit list, rounds as a loop).
module tb_magma_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         decrypt;
    logic [255:0] key;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;
    bit overlap_seen = 1'b0;

    localparam logic [255:0] TV_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  TV_PT  = 64'hfedcba9876543210;
    localparam logic [63:0]  TV_CT  = 64'h4ee901e5c2d8ca3d;

    // Row n: entry x lives at bits [63-4x -: 4].
    localparam logic [63:0] SB_ROW [8] = '{
        64'hC462A5B9E8D703F1,
        64'h68239A5C1E47BD0F,
        64'hB3582FADE174C960,
        64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C,
        64'h5DF692CAB78143E0,
        64'h8E25691CF4B0DA37,
        64'h17ED05834FA69CB2
    };

    magma_core dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .decrypt  (decrypt),
        .key      (key),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap_seen = 1'b1;

    function automatic logic [31:0] ref_g(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] s;
        logic [31:0] o;
        logic [63:0] row;
        int          x;
        s = a + k;
        o = '0;
        for (int n = 0; n < 8; n++) begin
            row = SB_ROW[n];
            x   = int'(s[4*n +: 4]);
            o[4*n +: 4] = row[63 - 4*x -: 4];
        end
        return {o[20:0], o[31:21]};
    endfunction

    function automatic logic [63:0] ref_cipher(input logic [255:0] k, input logic [63:0] b, input bit dec);
        int          enc_order [32];
        int          kn;
        logic [31:0] kw [8];
        logic [31:0] a1, a0, t;
        for (int i = 0; i < 8; i++) kw[i] = k[255 - 32*i -: 32];
        for (int i = 0; i < 24; i++) enc_order[i] = i % 8;
        for (int i = 24; i < 32; i++) enc_order[i] = 31 - i;
        a1 = b[63:32];
        a0 = b[31:0];
        for (int r = 0; r < 32; r++) begin
            kn = dec ? enc_order[31 - r] : enc_order[r];
            t  = ref_g(kw[kn], a0) ^ a1;
            a1 = a0;
            a0 = t;
        end
        return {a0, a1};
    endfunction

    function automatic logic [127:0] ref_pair(input logic [255:0] k, input logic [127:0] d, input bit dec);
        return {ref_cipher(k, d[127:64], dec), ref_cipher(k, d[63:0], dec)};
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 200);
    endtask

    // Starts an operation, then scrambles all inputs while it runs.
    task automatic run_op(input logic [255:0] k, input logic [127:0] d, input bit dec,
                          output logic [127:0] res, output int lat);
        key = k; data_in = d; decrypt = dec; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        key     = rand_key();
        data_in = rand_data();
        decrypt = ~dec;
        wait_done(lat);
        res = data_out;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] d1, d2;
        logic [255:0] k1;
        logic [255:0] kr;
        logic [127:0] dr;
        bit           dec_r;
        int           lat;
        int           dones;
        bit           busy_ok;

        reset = 1'b0; start = 1'b1; decrypt = 1'b0; key = TV_KEY; data_in = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data_out", data_out, 0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(TV_KEY, {TV_PT, TV_PT}, 0, res, lat);
        chk("enc_latency", lat, 64);
        chk("enc_tv", res, {TV_CT, TV_CT});
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("data_out_held", data_out, {TV_CT, TV_CT});

        run_op(TV_KEY, {TV_CT, TV_CT}, 1, res, lat);
        chk("dec_latency", lat, 64);
        chk("dec_tv", res, {TV_PT, TV_PT});

        run_op(TV_KEY, {64'h0, TV_PT}, 0, res, lat);
        chk("order_r0", res[63:0], TV_CT);
        chk("order_r1", res[127:64], ref_cipher(TV_KEY, 64'h0, 0));

        // Restart attempts while busy, then a back-to-back start in the done cycle.
        k1 = rand_key();
        d1 = rand_data();
        key = k1; data_in = d1; decrypt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_ok = 1'b1;
        dones   = 0;
        for (int c = 1; c <= 64; c++) begin
            if (c == 10 || c == 40) begin
                start = 1'b1; data_in = ~data_in; key = ~key; decrypt = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dones++;
            if (c < 64 && !busy) busy_ok = 1'b0;
        end
        chk("busy_held_64", busy_ok, 1);
        chk("done_at_64", done, 1);
        chk("busy_low_at_done", busy, 0);
        chk("single_done", dones, 1);
        chk("restart_ignored", data_out, ref_pair(k1, d1, 0));

        d2 = rand_data();
        key = k1; data_in = d2; decrypt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accepted", busy, 1);
        wait_done(lat);
        chk("b2b_latency", lat, 64);
        chk("b2b_result", data_out, ref_pair(k1, d2, 1));

        // Reset at cycle 30 of an operation.
        key = rand_key(); data_in = rand_data(); decrypt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_data_out", data_out, 0);
        dones = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("midrst_no_done", dones, 0);

        for (int n = 0; n < 8; n++) begin
            kr    = rand_key();
            dr    = rand_data();
            dec_r = bit'($urandom_range(0, 1));
            run_op(kr, dr, dec_r, res, lat);
            chk("rand_latency", lat, 64);
            chk("rand_result", res, ref_pair(kr, dr, dec_r));
        end

        chk("busy_done_overlap", overlap_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/magma_core.md
MAGMA_CORE -- requirements
Module: magma_core

Interface
REQ-001 clk  input  1  system clock; all state changes on the rising edge.
REQ-002 reset  input  1  synchronous, active-low reset.
REQ-003 start  input  1  request strobe; sampled only in IDLE.
REQ-004 decrypt  input  1  mode select, sampled with start: 0 = encrypt, 1 = decrypt.
REQ-005 key  input  256  cipher key; K1 = key[255:224] through K8 = key[31:0].
REQ-006 data_in  input  128  two 64-bit blocks: B0 = data_in[63:0], B1 = data_in[127:64].
REQ-007 data_out  output  128  result: R0 in [63:0], R1 in [127:64]; held until the next completion.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.

Function
REQ-010 Cipher: GOST R 34.12-2015 Magma, 64-bit block, 32 rounds, ECB; B0 processed first, then B1.
REQ-011 States: IDLE and RUN only.
REQ-012 IDLE with start=1 at edge T0: latch key, data_in and decrypt into internal registers; load B0; rnd=0; blk=0; state to RUN; busy=1.
REQ-013 IDLE with start=0: all registers hold.
REQ-014 RUN: exactly one round per clock edge; rnd increments by 1 each edge.
REQ-015 Block split: a1 = block[63:32], a0 = block[31:0].
REQ-016 Round function g(k,a) = rotl11(S(a + k mod 2^32)).
- S applies eight 4-bit S-boxes pi0..pi7 to nibbles 0..7; nibble 0 is the LSB.
- S-box values are the id-tc26-gost-28147-param-Z set.
REQ-017 Rounds 0-30: (a1,a0) <- (a0, g(k,a0) xor a1).
REQ-018 Round 31: result = (g(k,a0) xor a1) || a0; no swap.
REQ-019 Encrypt key order for round i: i<24 selects K[(i mod 8)+1]; i>=24 selects K[8-(i mod 8)].
REQ-020 Decrypt key order for round i: i<8 selects K[i+1]; i>=8 selects K[8-(i mod 8)].
REQ-021 Round 31 of blk 0: store the result in the R0 holding register; load latched B1; rnd wraps to 0; blk=1.
REQ-022 Round 31 of blk 1: data_out <= {result, R0}; done=1 for one cycle; busy=0; state to IDLE.
REQ-023 Latency: done is high in the cycle after edge T0+64, i.e. 64 cycles after start is sampled.
REQ-024 start while busy=1 is ignored; no queuing.
REQ-025 Changes to key, data_in or decrypt during RUN have no effect on the result.
REQ-026 Back-to-back operation: start=1 in the cycle where done=1 is accepted, since the state is IDLE.
REQ-027 busy and done are never high in the same cycle.

Reset
REQ-028 reset=0 at any edge forces: state IDLE, busy=0, done=0, data_out=0, rnd=0, blk=0, and all internal data/key registers to 0.
REQ-029 Reset mid-operation discards the operation; no done pulse is generated for it.
REQ-030 reset takes priority over start.

Structure
REQ-031 Package magma_pkg holds:
- the S-box table (8x16x4);
- ROUNDS=32, BLOCKS=2;
- the state encoding;
- the round-key index function for both modes.
REQ-032 One combinational sub-module, magma_round, implements one round: inputs a1, a0, k, last; output is the next 64-bit block.
REQ-033 magma_core holds the FSM, the counters, the latched operands, the R0 holding register and the output register.

Verification
REQ-034 Encrypt test vector:
- stimulus: key=ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, B0=B1=fedcba9876543210, decrypt=0, start pulse;
- response: done 64 cycles later; data_out=4ee901e5c2d8ca3d_4ee901e5c2d8ca3d.
REQ-035 Decrypt test vector:
- stimulus: same key, B0=B1=4ee901e5c2d8ca3d, decrypt=1;
- response: data_out=fedcba9876543210_fedcba9876543210.
REQ-036 Block order:
- stimulus: B0=fedcba9876543210, B1=0, encrypt;
- response: data_out[63:0]=4ee901e5c2d8ca3d; data_out[127:64] equals an independent single-block encryption of 0.
REQ-037 Busy/start handling:
- stimulus: start re-pulsed at cycles 10 and 40 with data_in changed; start pulsed again in the done cycle;
- response: the first result is unchanged; busy stays high through 64 cycles; exactly one done per accepted start; the second operation is accepted.
REQ-038 Reset mid-operation:
- stimulus: reset=0 at cycle 30 of an operation;
- response: busy=0, done=0, data_out=0 on the next cycle; no done pulse afterwards until a new start.
